// File: rtl/led_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_reg_pkg
// Description : Register map constants and frame sequencer state encoding
//               shared by the LED register controller.
// Revision    : 1.0 - initial release
// ============================================================================
package led_reg_pkg;

    localparam logic [6:0] c_addr_id        = 7'h00;
    localparam logic [6:0] c_addr_led       = 7'h01;
    localparam logic [6:0] c_addr_pix_index = 7'h02;
    localparam logic [6:0] c_addr_red       = 7'h03;
    localparam logic [6:0] c_addr_green     = 7'h04;
    localparam logic [6:0] c_addr_blue      = 7'h05;
    localparam logic [6:0] c_addr_ctrl      = 7'h06;

    localparam logic [7:0] c_id_value       = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/led_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_frame_sequencer
// Description : Walks the pixel memory once per frame toward the serializer,
//               then holds the line idle for the latch period.
// Revision    : 1.0 - initial release
// ============================================================================
module led_frame_sequencer
    import led_reg_pkg::*;
#(
    parameter int NUM_PIXELS   = 4,
    parameter int LATCH_CYCLES = 1500,
    parameter int IDX_W        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pixel_ready,
    output logic             pixel_valid,
    output logic             busy,
    output logic             pending,
    output logic             load,
    output logic [IDX_W-1:0] load_index
);

    localparam int               c_lat_w    = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_PIXELS - 1);
    localparam logic [c_lat_w-1:0] c_last_lat = c_lat_w'(LATCH_CYCLES - 1);

    seq_state_t         r_state;
    seq_state_t         w_state;
    logic [IDX_W-1:0]   r_count;
    logic [IDX_W-1:0]   w_count;
    logic [c_lat_w-1:0] r_latch;
    logic [c_lat_w-1:0] w_latch;
    logic               r_pending;
    logic               w_pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_latch   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_count   <= w_count;
            r_latch   <= w_latch;
            r_pending <= w_pending;
        end
    end

    // load/load_index tell the parent which memory word to present next cycle
    always_comb begin
        w_state    = r_state;
        w_count    = r_count;
        w_latch    = r_latch;
        w_pending  = r_pending;
        load       = 1'b0;
        load_index = '0;
        case (r_state)
            ST_IDLE: begin
                if (start || r_pending) begin
                    w_state   = ST_SEND;
                    w_count   = '0;
                    w_pending = 1'b0;
                    load      = 1'b1;
                end
            end
            ST_SEND: begin
                w_pending = r_pending | start;
                if (pixel_ready) begin
                    if (r_count == c_last_idx) begin
                        w_state = ST_LATCH;
                        w_latch = '0;
                    end else begin
                        w_count    = r_count + IDX_W'(1);
                        load       = 1'b1;
                        load_index = r_count + IDX_W'(1);
                    end
                end
            end
            ST_LATCH: begin
                if (r_latch == c_last_lat) begin
                    // a request landing on the final latch cycle survives as pending
                    w_pending = start;
                    if (r_pending) begin
                        w_state = ST_SEND;
                        w_count = '0;
                        load    = 1'b1;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end else begin
                    w_latch   = r_latch + c_lat_w'(1);
                    w_pending = r_pending | start;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign pixel_valid = (r_state == ST_SEND);
    assign busy        = (r_state != ST_IDLE);
    assign pending     = r_pending;

endmodule
`default_nettype wire

// File: rtl/led_reg_controller.sv
`default_nettype none
// ============================================================================
// Module      : led_reg_controller
// Description : I2C-slave register file driving the on-board RGB LED and a
//               WS2812B pixel chain through a frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module led_reg_controller
    import led_reg_pkg::*;
#(
    parameter int NUM_PIXELS   = 4,
    parameter int LATCH_CYCLES = 1500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  reg_address,
    input  logic        reg_is_write,
    input  logic        reg_request,
    input  logic [7:0]  reg_write_data,
    output logic        reg_response,
    output logic [7:0]  reg_read_data,
    output logic [2:0]  led_out,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    input  logic        pixel_ready,
    output logic        busy
);

    localparam int                 c_idx_w    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_PIXELS - 1);

    logic               r_wait_low;
    logic               r_response;
    logic [7:0]         r_read_data;
    logic [2:0]         r_led;
    logic [c_idx_w-1:0] r_pix_index;
    logic [7:0]         r_red;
    logic [7:0]         r_green;
    logic [7:0]         r_blue;
    logic [23:0]        r_mem [NUM_PIXELS];
    logic [23:0]        r_pixel_data;

    logic               w_accept;
    logic               w_wr;
    logic               w_rd;
    logic               w_mem_we;
    logic [23:0]        w_mem_wdata;
    logic               w_start;
    logic [c_idx_w-1:0] w_index_wdata;
    logic [c_idx_w-1:0] w_index_next;
    logic [7:0]         w_read_mux;
    logic               w_seq_pending;
    logic               w_load;
    logic [c_idx_w-1:0] w_load_index;

    // one access per request pulse: the request must drop before another is taken
    assign w_accept      = reg_request && !r_wait_low;
    assign w_wr          = w_accept && reg_is_write;
    assign w_rd          = w_accept && !reg_is_write;
    assign w_mem_we      = w_wr && (reg_address == c_addr_blue);
    assign w_mem_wdata   = {r_green, r_red, reg_write_data};
    assign w_start       = w_wr && (reg_address == c_addr_ctrl) && reg_write_data[0];
    assign w_index_wdata = (int'(reg_write_data) >= NUM_PIXELS) ? '0 : reg_write_data[c_idx_w-1:0];
    assign w_index_next  = (r_pix_index == c_last_idx) ? '0 : r_pix_index + c_idx_w'(1);

    always_comb begin
        w_read_mux = 8'h00;
        case (reg_address)
            c_addr_id:        w_read_mux = c_id_value;
            c_addr_led:       w_read_mux = {5'b0, r_led};
            c_addr_pix_index: w_read_mux = 8'(r_pix_index);
            c_addr_red:       w_read_mux = r_red;
            c_addr_green:     w_read_mux = r_green;
            c_addr_blue:      w_read_mux = r_blue;
            c_addr_ctrl:      w_read_mux = {6'b0, w_seq_pending, busy};
            default:          w_read_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_low  <= 1'b0;
            r_response  <= 1'b0;
            r_read_data <= 8'h00;
            r_led       <= 3'b000;
            r_pix_index <= '0;
            r_red       <= 8'h00;
            r_green     <= 8'h00;
            r_blue      <= 8'h00;
        end else begin
            r_response <= w_accept;
            if (w_accept) begin
                r_wait_low <= 1'b1;
            end else if (!reg_request) begin
                r_wait_low <= 1'b0;
            end
            if (w_rd) begin
                r_read_data <= w_read_mux;
            end
            if (w_wr) begin
                case (reg_address)
                    c_addr_led:       r_led       <= reg_write_data[2:0];
                    c_addr_pix_index: r_pix_index <= w_index_wdata;
                    c_addr_red:       r_red       <= reg_write_data;
                    c_addr_green:     r_green     <= reg_write_data;
                    c_addr_blue: begin
                        r_blue      <= reg_write_data;
                        r_pix_index <= w_index_next;
                    end
                    default: ;
                endcase
            end
        end
    end

    // pixel memory keeps its contents across reset
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_pix_index] <= w_mem_wdata;
        end
    end

    // the presented word is captured once so a stalled beat cannot change under the serializer
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pixel_data <= 24'h000000;
        end else if (w_load) begin
            if (w_mem_we && (r_pix_index == w_load_index)) begin
                r_pixel_data <= w_mem_wdata;
            end else begin
                r_pixel_data <= r_mem[w_load_index];
            end
        end
    end

    led_frame_sequencer #(
        .NUM_PIXELS   (NUM_PIXELS),
        .LATCH_CYCLES (LATCH_CYCLES),
        .IDX_W        (c_idx_w)
    ) u_frame_sequencer (
        .clock       (clock),
        .reset       (reset),
        .start       (w_start),
        .pixel_ready (pixel_ready),
        .pixel_valid (pixel_valid),
        .busy        (busy),
        .pending     (w_seq_pending),
        .load        (w_load),
        .load_index  (w_load_index)
    );

    assign reg_response  = r_response;
    assign reg_read_data = r_read_data;
    assign led_out       = r_led;
    assign pixel_data    = r_pixel_data;

endmodule
`default_nettype wire

// File: tb/tb_led_reg_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_reg_controller
// Description : Self-checking bench for led_reg_controller: register vectors,
//               randomized accesses against a reference model, frame sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_reg_controller;

    localparam int NUM_PIXELS   = 4;
    localparam int LATCH_CYCLES = 1500;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  reg_address;
    logic        reg_is_write;
    logic        reg_request;
    logic [7:0]  reg_write_data;
    logic        reg_response;
    logic [7:0]  reg_read_data;
    logic [2:0]  led_out;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic        pixel_ready;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit watch_idle = 1'b0;
    bit saw_idle   = 1'b0;

    led_reg_controller #(
        .NUM_PIXELS   (NUM_PIXELS),
        .LATCH_CYCLES (LATCH_CYCLES)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .reg_address    (reg_address),
        .reg_is_write   (reg_is_write),
        .reg_request    (reg_request),
        .reg_write_data (reg_write_data),
        .reg_response   (reg_response),
        .reg_read_data  (reg_read_data),
        .led_out        (led_out),
        .pixel_valid    (pixel_valid),
        .pixel_data     (pixel_data),
        .pixel_ready    (pixel_ready),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (watch_idle && !busy) saw_idle <= 1'b1;

    // reference model of the register file and pixel memory
    logic [2:0]  m_led;
    int          m_idx;
    logic [7:0]  m_r, m_g, m_b;
    logic [23:0] m_mem [NUM_PIXELS];

    function automatic void model_reset();
        m_led = 3'b0; m_idx = 0; m_r = 8'h0; m_g = 8'h0; m_b = 8'h0;
    endfunction

    function automatic void model_write(input logic [6:0] a, input logic [7:0] d);
        case (a)
            7'h01: m_led = d[2:0];
            7'h02: m_idx = (int'(d) < NUM_PIXELS) ? int'(d) : 0;
            7'h03: m_r = d;
            7'h04: m_g = d;
            7'h05: begin
                m_b = d;
                m_mem[m_idx] = {m_g, m_r, d};
                m_idx = (m_idx + 1) % NUM_PIXELS;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a, input logic [1:0] ctrl);
        case (a)
            7'h00:   return 8'hA5;
            7'h01:   return {5'b0, m_led};
            7'h02:   return 8'(m_idx);
            7'h03:   return m_r;
            7'h04:   return m_g;
            7'h05:   return m_b;
            7'h06:   return {6'b0, ctrl};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // tail=0 returns in the response cycle with the request already dropped
    task automatic access(input logic [6:0] a, input logic w, input logic [7:0] d,
                          input bit tail, output logic [7:0] rd);
        reg_address = a; reg_is_write = w; reg_write_data = d; reg_request = 1'b1;
        tick();
        check("resp_high", 32'(reg_response), 32'd1);
        rd = reg_read_data;
        reg_request = 1'b0;
        if (w) model_write(a, d);
        if (tail) begin
            tick();
            check("resp_low", 32'(reg_response), 32'd0);
        end
    endtask

    task automatic watch_frame(output int beats, output int latch);
        bit done = 1'b0;
        beats = 0; latch = 0;
        for (int i = 0; i < 4 * LATCH_CYCLES && !done; i++) begin
            if (pixel_valid) begin
                if (pixel_ready) begin
                    check("beat_data", 32'(pixel_data), 32'(m_mem[beats % NUM_PIXELS]));
                    beats++;
                end
            end else if (busy) begin
                latch++;
            end else begin
                done = 1'b1;
            end
            if (!done) tick();
        end
        check("frame_done", 32'(done), 32'd1);
    endtask

    typedef struct packed {
        logic [6:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] a, input logic w, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = d; v.exp = e;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [7:0]  rd;
        logic [23:0] d0;
        int          beats, latch, c0;

        reset = 1'b1; reg_address = 7'h0; reg_is_write = 1'b0; reg_request = 1'b0;
        reg_write_data = 8'h0; pixel_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_response", 32'(reg_response), 32'd0);
        check("rst_rdata", 32'(reg_read_data), 32'd0);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_led", 32'(led_out), 32'd0);

        // request held high yields a single response
        reg_address = 7'h00; reg_is_write = 1'b0; reg_request = 1'b1;
        tick();
        check("hold_resp1", 32'(reg_response), 32'd1);
        check("hold_rdata", 32'(reg_read_data), 32'hA5);
        tick();
        check("hold_resp2", 32'(reg_response), 32'd0);
        tick();
        check("hold_resp3", 32'(reg_response), 32'd0);
        reg_request = 1'b0;
        tick();
        check("rdata_held", 32'(reg_read_data), 32'hA5);

        vecs.push_back(mk(7'h00, 1'b0, 8'h00, 8'hA5));
        vecs.push_back(mk(7'h7F, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(7'h01, 1'b1, 8'h05, 8'h00));
        vecs.push_back(mk(7'h01, 1'b0, 8'h00, 8'h05));
        vecs.push_back(mk(7'h02, 1'b1, 8'h03, 8'h00));
        vecs.push_back(mk(7'h03, 1'b1, 8'h11, 8'h00));
        vecs.push_back(mk(7'h04, 1'b1, 8'h22, 8'h00));
        vecs.push_back(mk(7'h05, 1'b1, 8'h33, 8'h00));
        vecs.push_back(mk(7'h02, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(7'h02, 1'b1, 8'h09, 8'h00));
        vecs.push_back(mk(7'h02, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(7'h02, 1'b1, 8'h02, 8'h00));
        vecs.push_back(mk(7'h02, 1'b0, 8'h00, 8'h02));
        vecs.push_back(mk(7'h03, 1'b0, 8'h00, 8'h11));
        vecs.push_back(mk(7'h04, 1'b0, 8'h00, 8'h22));
        vecs.push_back(mk(7'h05, 1'b0, 8'h00, 8'h33));
        vecs.push_back(mk(7'h40, 1'b1, 8'hFF, 8'h00));
        vecs.push_back(mk(7'h40, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(7'h06, 1'b0, 8'h00, 8'h00));
        foreach (vecs[i]) begin
            access(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 1'b1, rd);
            if (!vecs[i].wr) check("vec_read", 32'(rd), 32'(vecs[i].exp));
            if (vecs[i].wr && vecs[i].addr == 7'h01) check("vec_led", 32'(led_out), 32'h5);
        end

        for (int i = 0; i < 150; i++) begin
            logic [6:0] a;
            logic       w;
            if ($urandom_range(0, 9) < 7) a = 7'($urandom_range(0, 6));
            else a = 7'($urandom_range(7, 127));
            w = 1'($urandom_range(0, 1));
            if (a == 7'h06) w = 1'b0;
            access(a, w, 8'($urandom), 1'b1, rd);
            if (!w) check("rand_read", 32'(rd), 32'(model_read(a, 2'b00)));
        end
        check("rand_led", 32'(led_out), 32'(m_led));

        // load every pixel, pixel 0 = R11 G22 B33
        access(7'h02, 1'b1, 8'h00, 1'b1, rd);
        for (int p = 0; p < NUM_PIXELS; p++) begin
            access(7'h03, 1'b1, (p == 0) ? 8'h11 : 8'($urandom), 1'b1, rd);
            access(7'h04, 1'b1, (p == 0) ? 8'h22 : 8'($urandom), 1'b1, rd);
            access(7'h05, 1'b1, (p == 0) ? 8'h33 : 8'($urandom), 1'b1, rd);
        end
        check("pix0_word", 32'(m_mem[0]), 32'h221133);

        pixel_ready = 1'b1;
        access(7'h06, 1'b1, 8'h01, 1'b0, rd);
        check("frame1_first", 32'(pixel_data), 32'h221133);
        watch_frame(beats, latch);
        check("frame1_beats", 32'(beats), 32'(NUM_PIXELS));
        check("frame1_latch", 32'(latch), 32'(LATCH_CYCLES));
        check("frame1_idle", 32'(busy), 32'd0);

        // start during latch chains a second frame with no idle gap
        access(7'h06, 1'b1, 8'h01, 1'b0, rd);
        for (int i = 0; i < 100 && pixel_valid; i++) tick();
        check("in_latch", 32'({pixel_valid, busy}), 32'b01);
        c0 = cyc;
        saw_idle = 1'b0; watch_idle = 1'b1;
        access(7'h06, 1'b1, 8'h01, 1'b1, rd);
        access(7'h06, 1'b0, 8'h00, 1'b1, rd);
        check("ctrl_pending", 32'(rd), 32'h03);
        for (int i = 0; i < 2 * LATCH_CYCLES && !pixel_valid; i++) tick();
        watch_idle = 1'b0;
        check("chain_latch", 32'(cyc - c0), 32'(LATCH_CYCLES));
        check("chain_no_idle", 32'(saw_idle), 32'd0);
        watch_frame(beats, latch);
        check("frame2_beats", 32'(beats), 32'(NUM_PIXELS));
        check("frame2_latch", 32'(latch), 32'(LATCH_CYCLES));
        access(7'h06, 1'b0, 8'h00, 1'b1, rd);
        check("ctrl_idle", 32'(rd), 32'h00);

        // stalled frame: data holds, an unsent pixel picks up a late write
        pixel_ready = 1'b0;
        access(7'h06, 1'b1, 8'h01, 1'b0, rd);
        d0 = pixel_data;
        check("stall_first", 32'(d0), 32'(m_mem[0]));
        tick();
        access(7'h02, 1'b1, 8'h02, 1'b1, rd);
        access(7'h03, 1'b1, 8'hAA, 1'b1, rd);
        access(7'h04, 1'b1, 8'hBB, 1'b1, rd);
        access(7'h05, 1'b1, 8'hCC, 1'b1, rd);
        for (int i = 0; i < 10; i++) begin
            check("stall_stable", 32'(pixel_data), 32'(d0));
            tick();
        end
        check("stall_valid", 32'(pixel_valid), 32'd1);
        pixel_ready = 1'b1;
        watch_frame(beats, latch);
        check("frame3_beats", 32'(beats), 32'(NUM_PIXELS));
        check("pix2_updated", 32'(m_mem[2]), 32'hBBAACC);

        // stall mid-frame then reset
        access(7'h06, 1'b1, 8'h01, 1'b0, rd);
        tick();
        tick();
        pixel_ready = 1'b0;
        d0 = pixel_data;
        check("mid_px2", 32'(d0), 32'(m_mem[2]));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_stable", 32'(pixel_data), 32'(d0));
        end
        check("mid_valid", 32'(pixel_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_mid_valid", 32'(pixel_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        model_reset();
        tick();
        check("rst_mid_led", 32'(led_out), 32'd0);
        access(7'h02, 1'b0, 8'h00, 1'b1, rd);
        check("rst_mid_index", 32'(rd), 32'd0);
        access(7'h03, 1'b0, 8'h00, 1'b1, rd);
        check("rst_mid_red", 32'(rd), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
